// File: rtl/bt_frame_receiver.sv
// Purpose: 8N1 UART receiver that gathers RX_DATA_BYTE_WIDTH bytes into one frame for the BlueTooth path.
// Latency: frame appears on rx_data with rx_rdy one cycle after the last byte's stop-bit centre sample.
// Backpressure: rx_rdy held until rx_ack; a frame completing while rx_rdy is still pending is dropped with an overrun pulse.
module bt_frame_receiver #(
    parameter int CLK_FRE            = 50,
    parameter int BAUD_RATE          = 9600,
    parameter int RX_DATA_BYTE_WIDTH = 11,
    parameter int TIMEOUT_BITS       = 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            uart_rx,
    output logic [RX_DATA_BYTE_WIDTH*8-1:0] rx_data,
    output logic                            rx_rdy,
    input  logic                            rx_ack,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            busy
);

    localparam int CYC_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int W           = RX_DATA_BYTE_WIDTH;
    localparam int TO_CYC      = TIMEOUT_BITS * CYC_PER_BIT;
    localparam int CNT_W       = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
    localparam int IDLE_W      = $clog2(TO_CYC + 1);
    localparam int BC_W        = $clog2(W + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CYC_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CYC_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_CYC - 1);
    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state;
    logic                rx_s1;
    logic                rx_s2;
    logic                rx_prev;
    logic [CNT_W-1:0]    cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic [BC_W-1:0]     byte_cnt;
    logic [W*8-1:0]      frame_buf;
    logic [W*8-1:0]      frame_next;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle-high reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Frame buffer with the just-received byte dropped into its slot
    always_comb begin
        frame_next = frame_buf;
        for (int k = 0; k < W; k++) begin
            if (byte_cnt == BC_W'(k)) begin
                frame_next[k*8 +: 8] = shift;
            end
        end
    end

    // Receive FSM: bit timing, byte assembly, frame hand-off, error and timeout handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idle_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
            frame_buf <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_rdy && rx_ack) begin
                rx_rdy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state    <= START;
                        cnt      <= '0;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                    end else if (byte_cnt != '0) begin
                        // partial frame waiting for its next byte: discard if the line stays idle too long
                        if (idle_cnt == IDLE_LAST) begin
                            byte_cnt  <= '0;
                            idle_cnt  <= '0;
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s2) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // glitch, not a start bit; only byte 0 owns the busy flag
                            state <= IDLE;
                            if (byte_cnt == '0) begin
                                busy <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s2) begin
                            state <= IDLE;
                            if (byte_cnt == BC_LAST) begin
                                byte_cnt <= '0;
                                busy     <= 1'b0;
                                // an ack in this same cycle frees the output for the new frame
                                if (!rx_rdy || rx_ack) begin
                                    rx_data <= frame_next;
                                    rx_rdy  <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_buf <= frame_next;
                                byte_cnt  <= byte_cnt + 1'b1;
                            end
                        end else begin
                            state     <= WAIT_HIGH;
                            byte_cnt  <= '0;
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bt_frame_receiver.sv
module tb_bt_frame_receiver;

    localparam int BIT = 434;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [23:0] rx_data;
    logic        rx_rdy;
    logic        rx_ack;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;

    bt_frame_receiver #(
        .CLK_FRE            (50),
        .BAUD_RATE          (115200),
        .RX_DATA_BYTE_WIDTH (3),
        .TIMEOUT_BITS       (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one 8N1 character, starting and ending on a falling clock edge
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        repeat (5) @(negedge clk);

        check("reset_rx_data", rx_data, 24'h0);
        check("reset_rx_rdy", rx_rdy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // first frame, consumer idle
        send_byte(8'h55, 1'b1);
        check("busy_between_bytes", busy, 1);
        send_byte(8'hA3, 1'b1);
        check("rdy_before_last", rx_rdy, 0);
        send_byte(8'h0F, 1'b1);
        check("frame1_rdy", rx_rdy, 1);
        check("frame1_data", rx_data, 24'h0FA355);
        check("frame1_busy_done", busy, 0);

        // second frame while first still pending
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        check("overrun_pulses", n_ovr, 1);
        check("overrun_data_kept", rx_data, 24'h0FA355);
        check("overrun_rdy_kept", rx_rdy, 1);

        // handshake
        ack_pulse();
        check("ack_clears_rdy", rx_rdy, 0);
        check("ack_data_kept", rx_data, 24'h0FA355);
        ack_pulse();
        check("ack_while_idle_ignored", rx_rdy, 0);

        // bad stop bit drops partial frame
        send_byte(8'h11, 1'b0);
        check("badstop_err", n_ferr, 1);
        check("badstop_busy", busy, 0);
        repeat (20) @(negedge clk);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check("after_badstop_rdy", rx_rdy, 1);
        check("after_badstop_data", rx_data, 24'h443322);
        check("no_extra_err", n_ferr, 1);
        ack_pulse();

        // inter-byte timeout
        send_byte(8'h11, 1'b1);
        repeat (19 * BIT) @(negedge clk);
        check("timeout_not_yet", n_ferr, 1);
        check("timeout_busy_before", busy, 1);
        repeat (BIT) @(negedge clk);
        check("timeout_err", n_ferr, 2);
        check("timeout_busy_after", busy, 0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        check("after_timeout_rdy", rx_rdy, 1);
        check("after_timeout_data", rx_data, 24'hCCBBAA);

        // short low glitch: false start, nothing flagged
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_busy", busy, 1);
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_busy_clear", busy, 0);
        check("glitch_no_err", n_ferr, 2);
        check("glitch_data_kept", rx_data, 24'hCCBBAA);

        // reset in the middle of the second byte
        send_byte(8'h12, 1'b1);
        uart_rx = 1'b0;
        repeat (BIT + 600) @(negedge clk);
        check("mid_byte_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rx_data", rx_data, 24'h0);
        check("arst_rx_rdy", rx_rdy, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_overrun", overrun, 0);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h7E, 1'b1);
        check("post_reset_rdy", rx_rdy, 1);
        check("post_reset_data", rx_data, 24'h7EC35A);
        check("post_reset_no_err", n_ferr, 2);
        ack_pulse();
        check("final_ack", rx_rdy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
